// File: rtl/riscv_dmem_ctrl.sv
// RV32I data-memory controller: handshaked byte/half/word access with wait states.
// Optional DMEM_MISALIGN_EN: misaligned half/word accesses are legal and wrap mod MEM_SIZE.
module riscv_dmem_ctrl #(
    parameter int NB_WORD     = 32,
    parameter int MEM_SIZE    = 128,
    parameter int NB_ADDR     = $clog2(MEM_SIZE),
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [2:0]         req_funct3,
    input  logic [NB_ADDR-1:0] req_addr,
    input  logic [NB_WORD-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [NB_WORD-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_LAST  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t               state;
    logic [3:0]           wcnt;

    logic                 wr_q;
    logic [2:0]           f3_q;
    logic [NB_ADDR-1:0]   addr_q;
    logic [NB_WORD-1:0]   wdata_q;

    logic [NB_WORD-1:0]   rd_q;
    logic                 err_q;

    logic [7:0]           mem [MEM_SIZE];

    logic [1:0]           size;
    logic                 f3_ok;
    logic                 mis;
    logic                 acc_err;
    logic [3:0]           be;
    logic [NB_ADDR-1:0]   addr_k [4];
    logic [NB_WORD-1:0]   word;
    logic [NB_WORD-1:0]   ld;

    // Decode the captured request: legality, byte lanes, addresses and load extension.
    always_comb begin
        size  = f3_q[1:0];
        f3_ok = 1'b0;
        mis   = 1'b0;
        if (wr_q) begin
            f3_ok = !f3_q[2] && (size != 2'd3);
        end else begin
            f3_ok = (size != 2'd3) && !(f3_q[2] && (size == 2'd2));
        end
`ifdef DMEM_MISALIGN_EN
        mis = 1'b0;
`else
        mis = ((size == 2'd1) && addr_q[0]) ||
              ((size == 2'd2) && (addr_q[1:0] != 2'b00));
`endif
        acc_err = !f3_ok || mis;
        be      = {{2{size == 2'd2}}, (size != 2'd0), 1'b1};
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_MISALIGN_EN
            addr_k[k] = addr_q + NB_ADDR'(k);
`else
            addr_k[k] = {addr_q[NB_ADDR-1:2], addr_q[1:0] + 2'(k)};
`endif
        end
        word = {mem[addr_k[3]], mem[addr_k[2]], mem[addr_k[1]], mem[addr_k[0]]};
        ld   = word;
        unique case (1'b1)
            (size == 2'd0): begin
                if (f3_q[2]) ld = {{(NB_WORD-8){1'b0}}, word[7:0]};
                else         ld = {{(NB_WORD-8){word[7]}}, word[7:0]};
            end
            (size == 2'd1): begin
                if (f3_q[2]) ld = {{(NB_WORD-16){1'b0}}, word[15:0]};
                else         ld = {{(NB_WORD-16){word[15]}}, word[15:0]};
            end
            default: ld = word;
        endcase
    end

    // Byte-lane store into the array during ACCESS; errors never write.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && wr_q && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[addr_k[k]] <= wdata_q[8*k +: 8];
            end
        end
    end

    // Request FSM; response outputs are registered on the way out of RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wr_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_wr;
                        f3_q      <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wcnt      <= 4'd0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= HAS_WAIT ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (wcnt == WS_LAST) state <= S_ACCESS;
                    else                 wcnt  <= wcnt + 4'd1;
                end
                S_ACCESS: begin
                    rd_q  <= (acc_err || wr_q) ? '0 : ld;
                    err_q <= acc_err;
                    state <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_q;
                    rsp_err   <= err_q;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Self-checking bench for riscv_dmem_ctrl against a byte-array reference model.
// Follows DMEM_MISALIGN_EN when the build defines it.
module tb_riscv_dmem_ctrl;

    localparam int WS = 1;
`ifdef DMEM_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [6:0]  req_addr = 7'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        xv [2];
    logic        xready [2];
    logic        xrv [2];
    logic        xerr [2];
    logic        xbusy [2];
    logic [31:0] xrd [2];

    always #5 clk = ~clk;

    riscv_dmem_ctrl #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    riscv_dmem_ctrl #(.WAIT_STATES(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(xv[0]), .req_ready(xready[0]),
        .req_wr(req_wr), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(xrv[0]), .rsp_rdata(xrd[0]),
        .rsp_err(xerr[0]), .busy(xbusy[0])
    );

    riscv_dmem_ctrl #(.WAIT_STATES(15)) dut_w15 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(xv[1]), .req_ready(xready[1]),
        .req_wr(req_wr), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(xrv[1]), .rsp_rdata(xrd[1]),
        .rsp_err(xerr[1]), .busy(xbusy[1])
    );

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        q [$];
    logic [7:0]  ref_mem [128];
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    bit          cmp_en = 1'b0;
    logic [31:0] last_rd = 32'd0;
    logic        last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain byte-array semantics of RV32I loads/stores.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [6:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int          n;
        bit          ok;
        logic [31:0] v;
        n = 1 << f3[1:0];
        if (wr) ok = (f3 <= 3'd2);
        else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        err = !ok || (!MIS && ((int'(a) % n) != 0));
        rd = 32'd0;
        v = 32'd0;
        if (err) return;
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (int'(a) + k) % 128;
            if (wr) ref_mem[idx] = wd[8*k +: 8];
            else    v[8*k +: 8] = ref_mem[idx];
        end
        if (!wr) begin
            if (n < 4 && !f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endtask

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [6:0] a,
                         input logic [31:0] wd, input bit keep, output int acc);
        exp_t e;
        int   t;
        acc = -1;
        @(negedge clk);
        req_wr = wr;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!req_ready) begin
            fails++;
            $display("FAIL accept_timeout: got ready=%b want 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        model(wr, f3, a, wd, e.rd, e.err);
        e.due = cyc + 2 + WS;
        q.push_back(e);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic err, output int rc);
        rc = -1;
        rd = 32'd0;
        err = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rd = rsp_rdata;
                err = rsp_err;
                rc = cyc;
                break;
            end
        end
        checks++;
        if (rc < 0) begin
            fails++;
            $display("FAIL rsp_timeout: got none want rsp_valid within 40 cycles");
        end
    endtask

    task automatic req(input logic wr, input logic [2:0] f3, input logic [6:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int acc, rc;
        issue(wr, f3, a, wd, 1'b0, acc);
        wait_rsp(rd, err, rc);
        chk("latency", 32'(rc - acc), 32'(2 + WS));
    endtask

    task automatic lit(input string name, input logic wr, input logic [2:0] f3,
                       input logic [6:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr);
        logic [31:0] rd;
        logic        err;
        req(wr, f3, a, wd, rd, err);
        chk(name, rd, erd);
        chk({name, "_err"}, {31'd0, err}, {31'd0, eerr});
    endtask

    task automatic xrun(input int i, input int ws, input logic wr, input logic [2:0] f3,
                        input logic [6:0] a, input logic [31:0] wd, input logic [31:0] erd);
        int acc, rc;
        @(negedge clk);
        req_wr = wr;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        chk("x_ready", {31'd0, xready[i]}, 32'd1);
        xv[i] = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        xv[i] = 1'b0;
        rc = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (xrv[i]) begin
                rc = cyc;
                chk("x_rdata", xrd[i], erd);
                chk("x_err", {31'd0, xerr[i]}, 32'd0);
                break;
            end
        end
        chk("x_latency", 32'(rc - acc), 32'(2 + ws));
    endtask

    // Cycle-level compare of the main DUT against the expectation queue.
    always @(negedge clk) begin
        bit ev, eb;
        if (rst_n && cmp_en) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                checks++;
                fails++;
                $display("FAIL missing_rsp: got none want rsp at cycle %0d", q[0].due);
                void'(q.pop_front());
            end
            ev = (q.size() > 0) && (q[0].due == cyc);
            eb = (q.size() > 0) && (q[0].due > cyc);
            chk("busy", {31'd0, busy}, {31'd0, eb});
            chk("req_ready", {31'd0, req_ready}, {31'd0, !eb});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
            if (ev) begin
                last_rd = q[0].rd;
                last_err = q[0].err;
                void'(q.pop_front());
            end
            chk("rsp_rdata", rsp_rdata, last_rd);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, last_err});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, wd;
        logic        err;
        int          a1, a2;
        xv[0] = 1'b0;
        xv[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        for (int w = 0; w < 32; w++) begin
            for (int k = 0; k < 4; k++) wd[8*k +: 8] = 8'(4*w + k);
            req(1'b1, 3'd2, 7'(4*w), wd, rd, err);
        end
        lit("init_lw20", 1'b0, 3'd2, 7'h20, 32'd0, 32'h2322_2120, 1'b0);

        lit("sw10", 1'b1, 3'd2, 7'h10, 32'h8765_4321, 32'd0, 1'b0);
        lit("lw10", 1'b0, 3'd2, 7'h10, 32'd0, 32'h8765_4321, 1'b0);
        lit("lb13", 1'b0, 3'd0, 7'h13, 32'd0, 32'hFFFF_FF87, 1'b0);
        lit("lbu13", 1'b0, 3'd4, 7'h13, 32'd0, 32'h0000_0087, 1'b0);
        lit("lh12", 1'b0, 3'd1, 7'h12, 32'd0, 32'hFFFF_8765, 1'b0);
        lit("lhu10", 1'b0, 3'd5, 7'h10, 32'd0, 32'h0000_4321, 1'b0);
        lit("sb11", 1'b1, 3'd0, 7'h11, 32'h0000_00AA, 32'd0, 1'b0);
        lit("lw10_sb", 1'b0, 3'd2, 7'h10, 32'd0, 32'h8765_AA21, 1'b0);
        lit("sh12", 1'b1, 3'd1, 7'h12, 32'h0000_1234, 32'd0, 1'b0);
        lit("lw10_sh", 1'b0, 3'd2, 7'h10, 32'd0, 32'h1234_AA21, 1'b0);
        lit("lb10_pos", 1'b0, 3'd0, 7'h10, 32'd0, 32'h0000_0021, 1'b0);

`ifdef DMEM_MISALIGN_EN
        lit("sw7e", 1'b1, 3'd2, 7'h7E, 32'hDDCC_BBAA, 32'd0, 1'b0);
        lit("lw7e", 1'b0, 3'd2, 7'h7E, 32'd0, 32'hDDCC_BBAA, 1'b0);
        lit("lbu7f", 1'b0, 3'd4, 7'h7F, 32'd0, 32'h0000_00BB, 1'b0);
        lit("lbu00", 1'b0, 3'd4, 7'h00, 32'd0, 32'h0000_00CC, 1'b0);
        lit("lh01", 1'b0, 3'd1, 7'h01, 32'd0, 32'h0000_02DD, 1'b0);
`else
        lit("lw11_mis", 1'b0, 3'd2, 7'h11, 32'd0, 32'd0, 1'b1);
        lit("sh13_mis", 1'b1, 3'd1, 7'h13, 32'h0000_FFFF, 32'd0, 1'b1);
        lit("lw10_keep", 1'b0, 3'd2, 7'h10, 32'd0, 32'h1234_AA21, 1'b0);
        lit("lhu11_mis", 1'b0, 3'd5, 7'h11, 32'd0, 32'd0, 1'b1);
`endif
        lit("st_f3_011", 1'b1, 3'd3, 7'h10, 32'hFFFF_FFFF, 32'd0, 1'b1);
        lit("ld_f3_110", 1'b0, 3'd6, 7'h10, 32'd0, 32'd0, 1'b1);
        lit("ld_f3_011", 1'b0, 3'd3, 7'h10, 32'd0, 32'd0, 1'b1);
        lit("lw10_final", 1'b0, 3'd2, 7'h10, 32'd0, 32'h1234_AA21, 1'b0);

        issue(1'b0, 3'd2, 7'h10, 32'd0, 1'b1, a1);
        issue(1'b0, 3'd5, 7'h12, 32'd0, 1'b0, a2);
        chk("b2b_gap", 32'(a2 - a1), 32'(3 + WS));
        repeat (8) @(negedge clk);
        chk("b2b_last", rsp_rdata, 32'h0000_1234);

        cmp_en = 1'b0;
        @(negedge clk);
        req_wr = 1'b1;
        req_funct3 = 3'd2;
        req_addr = 7'h20;
        req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_rdata", rsp_rdata, 32'd0);
        chk("arst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        last_rd = 32'd0;
        last_err = 1'b0;
        cmp_en = 1'b1;
        lit("lw20_after_abort", 1'b0, 3'd2, 7'h20, 32'd0, 32'h2322_2120, 1'b0);

        xrun(0, 0, 1'b1, 3'd2, 7'h20, 32'h1122_3344, 32'd0);
        xrun(0, 0, 1'b0, 3'd2, 7'h20, 32'd0, 32'h1122_3344);
        xrun(1, 15, 1'b1, 3'd2, 7'h20, 32'h5566_7788, 32'd0);
        xrun(1, 15, 1'b0, 3'd0, 7'h22, 32'd0, 32'h0000_0066);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
